qpsk_frame_ctrl: RTL and testbench

Transmit-side sequencer that feeds the QPSK modulator one dibit per handshake. Each burst is framed as an alternating preamble, then a fixed sync word, then the payload bytes split MSB-first into dibits, then an enforced idle gap. It sits between the byte-stream source (MAC/FIFO) and the modulator's `in_i`/`in_q`/`in_valid`/`in_ready` port, and it decides when the modulator runs.

---
 rtl/qpsk_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_qpsk_frame_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_frame_ctrl
// Purpose  : Transmit framer for the QPSK modulator. Emits one dibit per
//            handshake: alternating preamble, fixed sync word, payload bytes
//            split MSB-first, then an idle gap before the next burst.
// Revision : 1.0 - initial release
// ============================================================================
module qpsk_frame_ctrl #(
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter logic [15:0] SYNC_WORD    = 16'hE4B1,
   parameter int unsigned MAX_BYTES    = 256,
   parameter int unsigned GAP_LEN      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_i,
   output logic       out_q,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   // Shared phase counter covers preamble, sync (8 dibits) and gap lengths.
   localparam int unsigned C_CNT_TOP = (PREAMBLE_LEN > GAP_LEN)
                                     ? ((PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8)
                                     : ((GAP_LEN > 8) ? GAP_LEN : 8);
   localparam int unsigned C_CNT_W   = $clog2(C_CNT_TOP);
   localparam int unsigned C_BCNT_W  = $clog2(MAX_BYTES + 1);

   localparam logic [C_CNT_W-1:0]  C_PRE_LAST  = C_CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [C_CNT_W-1:0]  C_SYNC_LAST = C_CNT_W'(7);
   localparam logic [C_CNT_W-1:0]  C_GAP_LAST  = C_CNT_W'(GAP_LEN - 1);
   localparam logic [C_BCNT_W-1:0] C_BYTE_LAST = C_BCNT_W'(MAX_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SYNC     = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [C_CNT_W-1:0]    r_cnt;
   logic [7:0]            r_byte;
   logic [1:0]            r_idx;
   logic                  r_byte_valid;
   logic                  r_last_loaded;
   logic [C_BCNT_W-1:0]   r_byte_cnt;

   logic                  w_out_valid;
   logic                  w_in_ready;
   logic                  w_frame_done;
   logic                  w_underrun;
   logic                  w_busy;
   logic [1:0]            w_dibit;
   logic [1:0]            w_sync_dibit;
   logic [1:0]            w_byte_dibit;
   logic                  w_xfer;
   logic                  w_load;

   // Select the current sync and payload dibits, MSB pair first.
   always_comb begin
      w_sync_dibit = 2'b00;
      w_byte_dibit = 2'b00;
      case (r_cnt[2:0])
         3'd0:    w_sync_dibit = SYNC_WORD[15:14];
         3'd1:    w_sync_dibit = SYNC_WORD[13:12];
         3'd2:    w_sync_dibit = SYNC_WORD[11:10];
         3'd3:    w_sync_dibit = SYNC_WORD[9:8];
         3'd4:    w_sync_dibit = SYNC_WORD[7:6];
         3'd5:    w_sync_dibit = SYNC_WORD[5:4];
         3'd6:    w_sync_dibit = SYNC_WORD[3:2];
         default: w_sync_dibit = SYNC_WORD[1:0];
      endcase
      case (r_idx)
         2'd0:    w_byte_dibit = r_byte[7:6];
         2'd1:    w_byte_dibit = r_byte[5:4];
         2'd2:    w_byte_dibit = r_byte[3:2];
         default: w_byte_dibit = r_byte[1:0];
      endcase
   end

   // Next-state and output decode; everything derives from registered state
   // except the PAYLOAD reload path, which looks at out_ready.
   always_comb begin
      w_state_next = r_state;
      w_out_valid  = 1'b0;
      w_in_ready   = 1'b0;
      w_frame_done = 1'b0;
      w_underrun   = 1'b0;
      w_busy       = 1'b1;
      w_dibit      = 2'b00;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (in_valid) w_state_next = ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            w_out_valid = 1'b1;
            w_dibit     = {2{r_cnt[0]}};
            w_in_ready  = !r_last_loaded && !r_byte_valid;
            if (out_ready && (r_cnt == C_PRE_LAST)) w_state_next = ST_SYNC;
         end
         ST_SYNC: begin
            w_out_valid = 1'b1;
            w_dibit     = w_sync_dibit;
            w_in_ready  = !r_last_loaded && !r_byte_valid;
            if (out_ready && (r_cnt == C_SYNC_LAST)) w_state_next = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            w_out_valid = r_byte_valid;
            w_underrun  = !r_byte_valid;
            w_dibit     = r_byte_valid ? w_byte_dibit : 2'b00;
            w_in_ready  = !r_last_loaded &&
                          (!r_byte_valid || ((r_idx == 2'd3) && out_ready));
            if (r_byte_valid && out_ready && (r_idx == 2'd3) && r_last_loaded) begin
               w_frame_done = 1'b1;
               w_state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_cnt == C_GAP_LAST) w_state_next = ST_IDLE;
         end
         default: begin
            w_busy       = 1'b0;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_xfer = w_out_valid && out_ready;
   assign w_load = in_valid && w_in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Phase counter: restarts on every state change, steps on transfers
   // in preamble/sync and on every cycle of the gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_cnt <= '0;
      end else if ((r_state == ST_GAP) ||
                   (((r_state == ST_PREAMBLE) || (r_state == ST_SYNC)) && w_xfer)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Byte holding register; cleared while idle so each frame starts fresh.
   always_ff @(posedge clk) begin
      if (!rst_n || (r_state == ST_IDLE)) begin
         r_byte        <= 8'h00;
         r_idx         <= 2'd0;
         r_byte_valid  <= 1'b0;
         r_last_loaded <= 1'b0;
         r_byte_cnt    <= '0;
      end else begin
         if (w_load) begin
            r_byte       <= in_data;
            r_byte_valid <= 1'b1;
            r_byte_cnt   <= r_byte_cnt + 1'b1;
            if (in_last || (r_byte_cnt == C_BYTE_LAST)) r_last_loaded <= 1'b1;
         end else if ((r_state == ST_PAYLOAD) && w_xfer && (r_idx == 2'd3)) begin
            r_byte_valid <= 1'b0;
         end
         if ((r_state == ST_PAYLOAD) && w_xfer) r_idx <= r_idx + 2'd1;
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign out_i      = w_dibit[1];
   assign out_q      = w_dibit[0];
   assign busy       = w_busy;
   assign frame_done = w_frame_done;
   assign underrun   = w_underrun;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpsk_frame_ctrl
// Purpose  : Scoreboard bench for qpsk_frame_ctrl. Instance A uses
//            MAX_BYTES=256, instance B uses MAX_BYTES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpsk_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_valid_a, in_valid_b;
   logic       out_ready;

   logic in_ready_a, out_i_a, out_q_a, out_valid_a, busy_a, frame_done_a, underrun_a;
   logic in_ready_b, out_i_b, out_q_b, out_valid_b, busy_b, frame_done_b, underrun_b;

   int total = 0;
   int bad   = 0;

   logic [2:0] qa[$];   // {frame_done, i, q}
   logic [2:0] qb[$];
   int   ucnt_a  = 0;
   int   fdcnt_b = 0;
   int   falls_b = 0;
   logic busy_b_q = 1'b0;
   bit   bp_mode = 1'b0;

   // Preamble (4) then sync word E4B1 (8), hand-expanded.
   logic [1:0] hdr [0:11] = '{2'd0, 2'd3, 2'd0, 2'd3,
                              2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};

   always #5 clk = ~clk;

   qpsk_frame_ctrl #(.PREAMBLE_LEN(4), .SYNC_WORD(16'hE4B1), .MAX_BYTES(256), .GAP_LEN(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .out_i(out_i_a), .out_q(out_q_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
      .frame_done(frame_done_a), .underrun(underrun_a));

   qpsk_frame_ctrl #(.PREAMBLE_LEN(4), .SYNC_WORD(16'hE4B1), .MAX_BYTES(2), .GAP_LEN(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .out_i(out_i_b), .out_q(out_q_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
      .frame_done(frame_done_b), .underrun(underrun_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic push_hdr(input bit sel);
      for (int i = 0; i < 12; i++) begin
         if (sel) qb.push_back({1'b0, hdr[i]});
         else     qa.push_back({1'b0, hdr[i]});
      end
   endtask

   task automatic push_byte(input bit sel, input logic [1:0] d0, input logic [1:0] d1,
                            input logic [1:0] d2, input logic [1:0] d3, input bit done);
      if (sel) begin
         qb.push_back({1'b0, d0}); qb.push_back({1'b0, d1});
         qb.push_back({1'b0, d2}); qb.push_back({done, d3});
      end else begin
         qa.push_back({1'b0, d0}); qa.push_back({1'b0, d1});
         qa.push_back({1'b0, d2}); qa.push_back({done, d3});
      end
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] d, input bit last);
      bit ok = 1'b0;
      in_data = d;
      in_last = last;
      if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (sel ? in_ready_b : in_ready_a) begin
            ok = 1'b1;
            @(posedge clk); #1;
         end
      end
      if (!ok) fail_now("send_timeout");
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input bit sel);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (!(sel ? busy_b : busy_a)) ok = 1'b1;
      end
      if (!ok) fail_now("idle_timeout");
   endtask

   // out_ready driver: constant high, or the 1,0,0,1 stall pattern.
   initial begin
      int ph = 0;
      logic [3:0] pat = 4'b1001;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            out_ready = pat[3 - ph];
            ph = (ph + 1) % 4;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every transfer, checks hold while stalled.
   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (underrun_a) ucnt_a++;
            if (frame_done_b) fdcnt_b++;
            if (busy_b_q && !busy_b) falls_b++;
            busy_b_q = busy_b;
            if (out_valid_a) begin
               if (qa.size() == 0) fail_now("a_unexpected_dibit");
               else if (out_ready) begin
                  e = qa.pop_front();
                  check("a_dibit", {29'd0, frame_done_a, out_i_a, out_q_a}, {29'd0, e});
               end else begin
                  e = qa[0];
                  check("a_hold", {30'd0, out_i_a, out_q_a}, {30'd0, e[1:0]});
               end
            end else if (frame_done_a) fail_now("a_done_without_xfer");
            if (out_valid_b) begin
               if (qb.size() == 0) fail_now("b_unexpected_dibit");
               else if (out_ready) begin
                  e = qb.pop_front();
                  check("b_dibit", {29'd0, frame_done_b, out_i_b, out_q_b}, {29'd0, e});
               end else begin
                  e = qb[0];
                  check("b_hold", {30'd0, out_i_b, out_q_b}, {30'd0, e[1:0]});
               end
            end else if (frame_done_b) fail_now("b_done_without_xfer");
         end
      end
   end

   // Directed stimulus.
   initial begin
      int run, its;
      bit done;
      rst_n = 1'b0; in_data = 8'h00; in_last = 1'b0;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_in_ready",  in_ready_a, 0);
      check("rst_dibit",     {out_i_a, out_q_a}, 0);
      check("rst_busy",      busy_a, 0);
      check("rst_done_und",  {frame_done_a, underrun_a}, 0);
      check("rst_b_outputs", {out_valid_b, in_ready_b, busy_b, out_i_b, out_q_b}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single byte 0xA5, out_ready held high: 16 contiguous dibits from cycle 1.
      push_hdr(0); push_byte(0, 2'd2, 2'd2, 2'd1, 2'd1, 1'b1);
      ucnt_a = 0;
      in_data = 8'hA5; in_last = 1'b1; in_valid_a = 1'b1;
      @(negedge clk);
      check("lat_cycle0_valid", out_valid_a, 0);
      @(posedge clk); #1;
      run = 0; its = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         its++;
         if (out_valid_a) run++;
         if (frame_done_a) done = 1'b1;
         @(posedge clk); #1;
         in_valid_a = 1'b0;
      end
      check("single_done_seen", done, 1);
      check("single_run_len", run, 16);
      check("single_done_cycle", its, 16);
      @(negedge clk);
      check("gap1_busy_valid", {busy_a, out_valid_a}, 2'b10);
      @(negedge clk);
      check("gap2_busy_valid", {busy_a, out_valid_a}, 2'b10);
      @(negedge clk);
      check("after_gap_busy", busy_a, 0);
      check("single_queue_empty", qa.size(), 0);
      check("single_no_underrun", ucnt_a, 0);

      // Backpressure: same frame with out_ready cycling 1,0,0,1.
      @(posedge clk); #1;
      push_hdr(0); push_byte(0, 2'd2, 2'd2, 2'd1, 2'd1, 1'b1);
      bp_mode = 1'b1;
      send_byte(0, 8'hA5, 1'b1);
      wait_idle(0);
      bp_mode = 1'b0;
      check("bp_queue_empty", qa.size(), 0);

      // Underrun: second byte withheld for three payload cycles.
      repeat (2) @(posedge clk); #1;
      ucnt_a = 0;
      push_hdr(0);
      push_byte(0, 2'd3, 2'd0, 2'd0, 2'd3, 1'b0);   // 0xC3
      push_byte(0, 2'd1, 2'd1, 2'd2, 2'd2, 1'b1);   // 0x5A
      send_byte(0, 8'hC3, 1'b0);
      repeat (17) @(posedge clk); #1;
      send_byte(0, 8'h5A, 1'b1);
      wait_idle(0);
      check("underrun_cycles", ucnt_a, 3);
      check("underrun_queue_empty", qa.size(), 0);

      // Reset during sync, then a fresh frame from preamble index 0.
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) qa.push_back({1'b0, hdr[i]});
      in_data = 8'h3C; in_last = 1'b1; in_valid_a = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid_ready", {out_valid_a, in_ready_a}, 0);
      check("mid_rst_busy_dibit", {busy_a, out_i_a, out_q_a}, 0);
      check("mid_rst_pulses", {frame_done_a, underrun_a}, 0);
      check("mid_rst_partial_seen", qa.size(), 0);
      qa.delete();
      @(posedge clk); #1;
      push_hdr(0); push_byte(0, 2'd2, 2'd1, 2'd1, 2'd2, 1'b1);   // 0x96
      send_byte(0, 8'h96, 1'b1);
      wait_idle(0);
      check("restart_queue_empty", qa.size(), 0);

      // Forced end at MAX_BYTES=2 on instance B, no in_last anywhere.
      @(posedge clk); #1;
      fdcnt_b = 0; falls_b = 0;
      push_hdr(1);
      push_byte(1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);   // 0x00
      push_byte(1, 2'd3, 2'd3, 2'd3, 2'd3, 1'b1);   // 0xFF
      push_hdr(1);
      push_byte(1, 2'd0, 2'd3, 2'd3, 2'd0, 1'b0);   // 0x3C
      push_byte(1, 2'd2, 2'd1, 2'd1, 2'd2, 1'b1);   // 0x96
      send_byte(1, 8'h00, 1'b0);
      send_byte(1, 8'hFF, 1'b0);
      send_byte(1, 8'h3C, 1'b0);
      send_byte(1, 8'h96, 1'b0);
      wait_idle(1);
      check("max_frame_done_count", fdcnt_b, 2);
      check("max_busy_falls", falls_b, 2);
      check("max_queue_empty", qb.size(), 0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
